// File: rtl/universal_shift_reg_if.sv
// Control, data and status bundle for universal_shift_reg; master drives controls, slave is the register.
// Width parameters must match those of the attached universal_shift_reg instance.
interface universal_shift_reg_if #(
  parameter int DW = 8,
  parameter int SW = $clog2(DW) + 1
);
  logic          sync_rst;
  logic          load;
  logic          en;
  logic          start;
  logic [2:0]    mode;
  logic [SW-1:0] amt;
  logic [DW-1:0] data;
  logic          data_h;
  logic          data_l;
  logic [DW-1:0] q;
  logic          sout;
  logic          busy;
  logic          done;

  modport master (
    output sync_rst, load, en, start, mode, amt, data, data_h, data_l,
    input  q, sout, busy, done
  );

  modport slave (
    input  sync_rst, load, en, start, mode, amt, data, data_h, data_l,
    output q, sout, busy, done
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Shift register with load, SRL/SLL/ROR/ROL/SRA modes and counted bursts; SRA only when USR_ARITH_EN is defined.
// One edge per shift; bursts stall while en=0 (busy held) and pulse done the cycle after the last shift.
module universal_shift_reg #(
  parameter int DW = 8,
  parameter int SW = $clog2(DW) + 1
) (
  input  logic               clk,
  input  logic               async_rst,
  universal_shift_reg_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  state_t        state, state_n;
  logic [DW-1:0] q_r, q_n;
  logic          sout_r, sout_n;
  logic          done_r, done_n;
  logic [SW-1:0] cnt, cnt_n;
  logic [2:0]    mode_r, mode_r_n;

  logic [2:0]    sel_mode;
  logic [DW-1:0] sh_q;
  logic          sh_out;

  // A running burst keeps the mode latched at start; single steps use the live mode.
  assign sel_mode = (state == SHIFT) ? mode_r : bus.mode;

  always_comb begin
    sh_q   = q_r;
    sh_out = sout_r;
    case (sel_mode)
      3'b000: begin sh_q = {bus.data_h, q_r[DW-1:1]}; sh_out = q_r[0];    end
      3'b001: begin sh_q = {q_r[DW-2:0], bus.data_l}; sh_out = q_r[DW-1]; end
      3'b010: begin sh_q = {q_r[0], q_r[DW-1:1]};     sh_out = q_r[0];    end
      3'b011: begin sh_q = {q_r[DW-2:0], q_r[DW-1]};  sh_out = q_r[DW-1]; end
`ifdef USR_ARITH_EN
      3'b100: begin sh_q = {q_r[DW-1], q_r[DW-1:1]};  sh_out = q_r[0];    end
`else
      3'b100: ;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_n  = state;
    q_n      = q_r;
    sout_n   = sout_r;
    cnt_n    = cnt;
    mode_r_n = mode_r;
    done_n   = 1'b0;
    if (bus.sync_rst) begin
      state_n  = IDLE;
      q_n      = '0;
      sout_n   = 1'b0;
      cnt_n    = '0;
      mode_r_n = 3'b000;
    end else if (bus.load) begin
      // Loading during a burst aborts it without a done pulse.
      q_n     = bus.data;
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.amt == '0) begin
              done_n = 1'b1;
            end else begin
              q_n    = sh_q;
              sout_n = sh_out;
              if (bus.amt == CNT_ONE) begin
                done_n = 1'b1;
              end else begin
                mode_r_n = bus.mode;
                cnt_n    = bus.amt - CNT_ONE;
                state_n  = SHIFT;
              end
            end
          end else if (bus.en) begin
            q_n    = sh_q;
            sout_n = sh_out;
          end
        end
        SHIFT: begin
          if (bus.en) begin
            q_n    = sh_q;
            sout_n = sh_out;
            cnt_n  = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state  <= IDLE;
      q_r    <= '0;
      sout_r <= 1'b0;
      done_r <= 1'b0;
      cnt    <= '0;
      mode_r <= 3'b000;
    end else begin
      state  <= state_n;
      q_r    <= q_n;
      sout_r <= sout_n;
      done_r <= done_n;
      cnt    <= cnt_n;
      mode_r <= mode_r_n;
    end
  end

  assign bus.q    = q_r;
  assign bus.sout = sout_r;
  assign bus.done = done_r;
  assign bus.busy = (state == SHIFT);
endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed-vector bench for universal_shift_reg (DW=8); expectations follow USR_ARITH_EN.
module tb_universal_shift_reg;
  localparam int DW = 8;
  localparam int SW = $clog2(DW) + 1;

  logic clk = 1'b0;
  logic async_rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  universal_shift_reg_if #(.DW(DW), .SW(SW)) bus ();

  universal_shift_reg #(.DW(DW), .SW(SW)) dut (
    .clk       (clk),
    .async_rst (async_rst),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns so outputs are sampled off-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [7:0] q, input logic sout,
                        input logic busy, input logic done);
    check({tag, ".q"},    32'(bus.q),    32'(q));
    check({tag, ".sout"}, 32'(bus.sout), 32'(sout));
    check({tag, ".busy"}, 32'(bus.busy), 32'(busy));
    check({tag, ".done"}, 32'(bus.done), 32'(done));
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.load = 1'b1;
    bus.data = v;
    step();
    bus.load = 1'b0;
  endtask

  logic [7:0] sra1, sra2, sra_b1, sra_b2;

  initial begin
`ifdef USR_ARITH_EN
    sra1 = 8'hC8; sra2 = 8'hE4; sra_b1 = 8'hF2; sra_b2 = 8'hF9;
`else
    sra1 = 8'h90; sra2 = 8'h90; sra_b1 = 8'h90; sra_b2 = 8'h90;
`endif
    async_rst = 1'b1;
    bus.sync_rst = 1'b0; bus.load = 1'b0; bus.en = 1'b0; bus.start = 1'b0;
    bus.mode = 3'b000; bus.amt = '0; bus.data = '0; bus.data_h = 1'b0; bus.data_l = 1'b0;
    step();
    chk_st("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    async_rst = 1'b0;

    // 1: async reset off-edge after building non-zero state
    do_load(8'h5A);
    check("t1.load", 32'(bus.q), 32'h5A);
    bus.en = 1'b1; bus.mode = 3'b000;
    step();
    chk_st("t1.srl1", 8'h2D, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1; bus.amt = 4'd4; // burst ROR-free SRL, leaves busy=1
    step();
    bus.start = 1'b0; bus.en = 1'b0;
    chk_st("t1.burst", 8'h16, 1'b1, 1'b1, 1'b0);
    #2;
    async_rst = 1'b1;
    #1;
    chk_st("t1.arst", 8'h00, 1'b0, 1'b0, 1'b0);
    async_rst = 1'b0;

    // 2: hold with en=0, then synchronous clear
    do_load(8'hA5);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2.hold", 32'(bus.q), 32'hA5);
    end
    bus.sync_rst = 1'b1;
    step();
    bus.sync_rst = 1'b0;
    check("t2.sync_rst", 32'(bus.q), 32'h00);

    // 3: single-step SRL with data_h=1
    do_load(8'hB4);
    bus.mode = 3'b000; bus.data_h = 1'b1; bus.en = 1'b1;
    step();
    chk_st("t3.s1", 8'hDA, 1'b0, 1'b0, 1'b0);
    step();
    chk_st("t3.s2", 8'hED, 1'b0, 1'b0, 1'b0);
    bus.en = 1'b0; bus.data_h = 1'b0;

    // 4: ROL burst of 3; mode change mid-burst ignored
    do_load(8'h81);
    bus.start = 1'b1; bus.amt = 4'd3; bus.mode = 3'b011; bus.en = 1'b1;
    step();
    bus.start = 1'b0; bus.mode = 3'b000;
    chk_st("t4.e1", 8'h03, 1'b1, 1'b1, 1'b0);
    step();
    chk_st("t4.e2", 8'h06, 1'b0, 1'b1, 1'b0);
    step();
    chk_st("t4.e3", 8'h0C, 1'b0, 1'b0, 1'b1);
    bus.en = 1'b0;
    step();
    check("t4.done_clr", 32'(bus.done), 32'h0);

    // 4b: same burst with a one-cycle pause
    do_load(8'h81);
    bus.start = 1'b1; bus.amt = 4'd3; bus.mode = 3'b011; bus.en = 1'b1;
    step();
    bus.start = 1'b0; bus.en = 1'b0;
    chk_st("t4b.e1", 8'h03, 1'b1, 1'b1, 1'b0);
    step();
    chk_st("t4b.pause", 8'h03, 1'b1, 1'b1, 1'b0);
    bus.en = 1'b1;
    step();
    chk_st("t4b.e2", 8'h06, 1'b0, 1'b1, 1'b0);
    step();
    chk_st("t4b.e3", 8'h0C, 1'b0, 1'b0, 1'b1);
    bus.en = 1'b0;
    step();
    check("t4b.done_clr", 32'(bus.done), 32'h0);

    // 5: mode 100 single steps and a burst
    do_load(8'h90);
    bus.mode = 3'b100; bus.en = 1'b1;
    step();
    chk_st("t5.s1", sra1, 1'b0, 1'b0, 1'b0);
    step();
    chk_st("t5.s2", sra2, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1; bus.amt = 4'd2;
    step();
    bus.start = 1'b0;
    chk_st("t5.b1", sra_b1, 1'b0, 1'b1, 1'b0);
    step();
    check("t5.b2.q", 32'(bus.q), 32'(sra_b2));
    check("t5.b2.done", 32'(bus.done), 32'h1);
    bus.en = 1'b0;

    // 6: load aborts a burst; amt=0 pulses done only
    do_load(8'h0F);
    bus.start = 1'b1; bus.amt = 4'd5; bus.mode = 3'b000; bus.data_h = 1'b0; bus.en = 1'b1;
    step();
    bus.start = 1'b0;
    chk_st("t6.e1", 8'h07, 1'b1, 1'b1, 1'b0);
    step();
    chk_st("t6.e2", 8'h03, 1'b1, 1'b1, 1'b0);
    bus.load = 1'b1; bus.data = 8'h3C;
    step();
    bus.load = 1'b0; bus.en = 1'b0;
    chk_st("t6.abort", 8'h3C, 1'b1, 1'b0, 1'b0);
    step();
    chk_st("t6.after", 8'h3C, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b1; bus.amt = 4'd0;
    step();
    bus.start = 1'b0;
    chk_st("t6.amt0", 8'h3C, 1'b1, 1'b0, 1'b1);
    step();
    check("t6.amt0_clr", 32'(bus.done), 32'h0);

    // amt=1 SLL with data_l=1: single shift and immediate done
    bus.start = 1'b1; bus.amt = 4'd1; bus.mode = 3'b001; bus.data_l = 1'b1;
    step();
    bus.start = 1'b0;
    chk_st("amt1", 8'h79, 1'b0, 1'b0, 1'b1);

    // hold code 111 leaves q and sout
    bus.mode = 3'b111; bus.en = 1'b1;
    step();
    chk_st("hold111", 8'h79, 1'b0, 1'b0, 1'b0);

    // ROR single step
    bus.mode = 3'b010;
    step();
    chk_st("ror", 8'hBC, 1'b1, 1'b0, 1'b0);
    bus.en = 1'b0;

    // sync_rst mid-burst: full clear, no done
    bus.start = 1'b1; bus.amt = 4'd4; bus.mode = 3'b011; bus.en = 1'b1;
    step();
    bus.start = 1'b0;
    chk_st("sr.e1", 8'h79, 1'b1, 1'b1, 1'b0);
    bus.sync_rst = 1'b1;
    step();
    bus.sync_rst = 1'b0; bus.en = 1'b0;
    chk_st("sr.clr", 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    chk_st("sr.after", 8'h00, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
